rpn_stack_alu: RTL

RPN_STACK_ALU -- requirements
Module: rpn_stack_alu

---
 rtl/rpn_stack_alu.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/rpn_stack_alu.sv
// RPN calculator front-end driving an external 16x8 stack (push/pop strobes, top-of-stack read port).
// Optional macro RPN_SAT_EN: ADD saturates at 0xFF and SUB clamps at 0x00 instead of wrapping.
module rpn_stack_alu (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       res_valid,
    output logic [7:0] res_data,
    output logic       err,
    output logic [4:0] depth,
    output logic       stk_push,
    output logic       stk_pop,
    output logic [7:0] stk_wdata,
    input  logic [7:0] stk_rdata,
    output logic [1:0] dbg_state
);

    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // cmd_ready is high only in IDLE, and cmd_op/cmd_data are sampled only on that edge.

    localparam logic [2:0] OP_PUSH = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_DUP  = 3'b110;
    localparam logic [2:0] OP_POP  = 3'b111;

    localparam logic [4:0] DEPTH_MAX = 5'd16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        POP_A = 2'd1,
        POP_B = 2'd2,
        WR    = 2'd3
    } state_t;

    state_t     state;
    logic [2:0] op_r;
    logic [7:0] opa;
    logic       legal;

    assign dbg_state = state;

    // Result is b op a, where b is the deeper operand and a was the top.
    function automatic logic [7:0] alu(input logic [2:0] op, input logic [7:0] b, input logic [7:0] a);
`ifdef RPN_SAT_EN
        logic [8:0] sum;
        logic [8:0] diff;
        sum  = {1'b0, b} + {1'b0, a};
        diff = {1'b0, b} - {1'b0, a};
`endif
        case (op)
`ifdef RPN_SAT_EN
            OP_ADD:  alu = sum[8] ? 8'hFF : sum[7:0];
            OP_SUB:  alu = diff[8] ? 8'h00 : diff[7:0];
`else
            OP_ADD:  alu = b + a;
            OP_SUB:  alu = b - a;
`endif
            OP_AND:  alu = b & a;
            OP_OR:   alu = b | a;
            OP_XOR:  alu = b ^ a;
            default: alu = 8'h00;
        endcase
    endfunction

    always_comb begin
        legal = 1'b0;
        case (cmd_op)
            OP_PUSH, OP_DUP: legal = (depth != DEPTH_MAX);
            OP_POP:          legal = (depth != 5'd0);
            default:         legal = (depth >= 5'd2);
        endcase
    end

    // Strobes are registered on the transition into the state that owns them,
    // so each is high exactly while the FSM sits in POP_A/POP_B/WR.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            op_r      <= 3'd0;
            opa       <= 8'h00;
            depth     <= 5'd0;
            cmd_ready <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= 8'h00;
            err       <= 1'b0;
            stk_push  <= 1'b0;
            stk_pop   <= 1'b0;
            stk_wdata <= 8'h00;
        end else begin
            res_valid <= 1'b0;
            err       <= 1'b0;
            stk_push  <= 1'b0;
            stk_pop   <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        op_r <= cmd_op;
                        if (!legal) begin
                            err <= 1'b1;
                        end else begin
                            cmd_ready <= 1'b0;
                            case (cmd_op)
                                OP_PUSH: begin
                                    stk_wdata <= cmd_data;
                                    stk_push  <= 1'b1;
                                    state     <= WR;
                                end
                                OP_DUP: begin
                                    stk_wdata <= stk_rdata;
                                    stk_push  <= 1'b1;
                                    state     <= WR;
                                end
                                OP_POP: begin
                                    res_data  <= stk_rdata;
                                    res_valid <= 1'b1;
                                    stk_pop   <= 1'b1;
                                    state     <= POP_A;
                                end
                                default: begin
                                    stk_pop <= 1'b1;
                                    state   <= POP_A;
                                end
                            endcase
                        end
                    end
                end
                POP_A: begin
                    depth <= depth - 5'd1;
                    if (op_r == OP_POP) begin
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        opa     <= stk_rdata;
                        stk_pop <= 1'b1;
                        state   <= POP_B;
                    end
                end
                POP_B: begin
                    // stk_rdata now shows the element below the one taken in POP_A.
                    depth     <= depth - 5'd1;
                    stk_wdata <= alu(op_r, stk_rdata, opa);
                    res_data  <= alu(op_r, stk_rdata, opa);
                    res_valid <= 1'b1;
                    stk_push  <= 1'b1;
                    state     <= WR;
                end
                WR: begin
                    depth     <= depth + 5'd1;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
